// File: rtl/draw_rect_fill.sv
// Rectangle filler: sweeps a latched rectangle in raster order, one registered
// pixel per clock, with optional checker colouring and off-screen clipping.
module draw_rect_fill #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      xPosition,
    input  logic [Y_W-1:0]      yPosition,
    input  logic [X_W-1:0]      rectW,
    input  logic [Y_W-1:0]      rectH,
    input  logic [COLOUR_W-1:0] colourIn,
    input  logic [COLOUR_W-1:0] colourAlt,
    input  logic                mode,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colourOut,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam logic [X_W:0] LP_SCREEN_W = SCREEN_W[X_W:0];
    localparam logic [Y_W:0] LP_SCREEN_H = SCREEN_H[Y_W:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [X_W-1:0]      r_x0;
    logic [Y_W-1:0]      r_y0;
    logic [X_W-1:0]      r_w;
    logic [Y_W-1:0]      r_h;
    logic [COLOUR_W-1:0] r_ci;
    logic [COLOUR_W-1:0] r_ca;
    logic                r_mode;
    logic [X_W-1:0]      r_cx;
    logic [Y_W-1:0]      r_cy;

    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;
    logic                r_busy;
    logic                r_done;

    logic [X_W-1:0]      w_cx_inc;
    logic [Y_W-1:0]      w_cy_inc;
    logic                w_last_x;
    logic                w_last;
    logic                w_zero_size;
    logic [X_W:0]        w_sum_x;
    logic [Y_W:0]        w_sum_y;
    logic                w_on_screen;
    logic                w_alt;

    assign w_cx_inc    = r_cx + X_W'(1);
    assign w_cy_inc    = r_cy + Y_W'(1);
    assign w_last_x    = (w_cx_inc == r_w);
    assign w_last      = w_last_x && (w_cy_inc == r_h);
    assign w_zero_size = (rectW == '0) || (rectH == '0);

    // Sums are one bit wider so a rectangle running past the coordinate range
    // is still recognised as off screen rather than wrapping back on.
    assign w_sum_x     = {1'b0, r_x0} + {1'b0, r_cx};
    assign w_sum_y     = {1'b0, r_y0} + {1'b0, r_cy};
    assign w_on_screen = (w_sum_x < LP_SCREEN_W) && (w_sum_y < LP_SCREEN_H);
    assign w_alt       = r_mode && (r_cx[0] ^ r_cy[0]);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_zero_size ? S_FINISH : S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_last) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x0     <= '0;
            r_y0     <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_ci     <= '0;
            r_ca     <= '0;
            r_mode   <= 1'b0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x0   <= xPosition;
                        r_y0   <= yPosition;
                        r_w    <= rectW;
                        r_h    <= rectH;
                        r_ci   <= colourIn;
                        r_ca   <= colourAlt;
                        r_mode <= mode;
                        r_cx   <= '0;
                        r_cy   <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_DRAW: begin
                    r_x      <= w_sum_x[X_W-1:0];
                    r_y      <= w_sum_y[Y_W-1:0];
                    r_colour <= w_alt ? r_ca : r_ci;
                    r_plot   <= w_on_screen;
                    // Counters advance on clipped pixels too, keeping the fill length fixed.
                    if (w_last_x) begin
                        r_cx <= '0;
                        r_cy <= w_cy_inc;
                    end else begin
                        r_cx <= w_cx_inc;
                    end
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign x         = r_x;
    assign y         = r_y;
    assign colourOut = r_colour;
    assign plot      = r_plot;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_draw_rect_fill.sv
// Bench for draw_rect_fill: table of fills checked against a pixel scoreboard,
// plus hand sequences for start-while-busy and reset in the middle of a fill.
module tb_draw_rect_fill;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] xPosition = '0;
    logic [6:0] yPosition = '0;
    logic [7:0] rectW = '0;
    logic [6:0] rectH = '0;
    logic [2:0] colourIn = '0;
    logic [2:0] colourAlt = '0;
    logic       mode = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colourOut;
    logic       plot;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    draw_rect_fill dut (
        .clock(clock), .resetn(resetn), .start(start),
        .xPosition(xPosition), .yPosition(yPosition),
        .rectW(rectW), .rectH(rectH),
        .colourIn(colourIn), .colourAlt(colourAlt), .mode(mode),
        .x(x), .y(y), .colourOut(colourOut),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x0;
        logic [6:0] y0;
        logic [7:0] w;
        logic [6:0] h;
        logic [2:0] ci;
        logic [2:0] ca;
        logic       m;
        int         exp_plots;
        int         exp_done_n;   // negedge index of done, counting 1 right after the start edge
    } vec_t;

    typedef struct {
        int         cyc;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t q[$];
    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // stop_n > 0 returns right after sampling that cycle (used for mid-fill reset).
    task automatic run_fill(input vec_t v, input int disturb_n, input int stop_n);
        int plots;
        int done_n;
        pix_t p;
        q.delete();
        for (int cy = 0; cy < int'(v.h); cy++) begin
            for (int cx = 0; cx < int'(v.w); cx++) begin
                int wx;
                int wy;
                wx = int'(v.x0) + cx;
                wy = int'(v.y0) + cy;
                if (wx < 160 && wy < 120) begin
                    p.cyc = cy * int'(v.w) + cx + 2;
                    p.px  = wx[7:0];
                    p.py  = wy[6:0];
                    p.pc  = (v.m && (((cx ^ cy) & 1) != 0)) ? v.ca : v.ci;
                    q.push_back(p);
                end
            end
        end
        @(negedge clock);
        xPosition = v.x0; yPosition = v.y0; rectW = v.w; rectH = v.h;
        colourIn = v.ci; colourAlt = v.ca; mode = v.m; start = 1'b1;
        plots = 0;
        done_n = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clock);
            if (plot) begin
                plots++;
                if (q.size() == 0) begin
                    chk("extra_plot_cycle", n, 0);
                end else begin
                    p = q.pop_front();
                    $display("pixel cyc=%0d x=%0d y=%0d c=%0d", n, x, y, colourOut);
                    chk("pix_cycle", n, p.cyc);
                    chk("pix_x", int'(x), int'(p.px));
                    chk("pix_y", int'(y), int'(p.py));
                    chk("pix_colour", int'(colourOut), int'(p.pc));
                end
            end
            if (done) begin
                done_n = n;
                chk("done_plot_low", int'(plot), 0);
                chk("done_busy_low", int'(busy), 0);
                break;
            end
            chk("busy_during_fill", int'(busy), 1);
            if (n == stop_n) return;
            if (n == disturb_n) begin
                start = 1'b1;
                xPosition = v.x0 + 8'd9; yPosition = v.y0 + 7'd3;
                rectW = v.w + 8'd2; colourIn = ~v.ci; mode = ~v.m;
            end else begin
                start = 1'b0;
            end
        end
        chk("done_cycle", done_n, v.exp_done_n);
        chk("plot_count", plots, v.exp_plots);
        chk("queue_empty", q.size(), 0);
        $display("fill x0=%0d y0=%0d w=%0d h=%0d m=%0d plots=%0d done_n=%0d",
                 v.x0, v.y0, v.w, v.h, v.m, plots, done_n);
        @(negedge clock);
        chk("done_one_cycle", int'(done), 0);
        chk("idle_busy_low", int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{8'd10,  7'd20,  8'd3,  7'd2, 3'b100, 3'b000, 1'b0, 6, 8};
        vecs[1] = '{8'd0,   7'd0,   8'd2,  7'd2, 3'b001, 3'b110, 1'b1, 4, 6};
        vecs[2] = '{8'd158, 7'd118, 8'd4,  7'd4, 3'b010, 3'b000, 1'b0, 4, 18};
        vecs[3] = '{8'd5,   7'd5,   8'd0,  7'd5, 3'b111, 3'b000, 1'b0, 0, 2};
        vecs[4] = '{8'd1,   7'd1,   8'd4,  7'd0, 3'b111, 3'b000, 1'b0, 0, 2};
        vecs[5] = '{8'd50,  7'd60,  8'd3,  7'd3, 3'b011, 3'b101, 1'b1, 9, 11};
        vecs[6] = '{8'd250, 7'd10,  8'd10, 7'd1, 3'b110, 3'b000, 1'b0, 0, 12};
        vecs[7] = '{8'd5,   7'd119, 8'd2,  7'd3, 3'b101, 3'b000, 1'b0, 2, 8};
        vecs[8] = '{8'd20,  7'd30,  8'd4,  7'd4, 3'b001, 3'b010, 1'b1, 16, 18};

        repeat (2) @(negedge clock);
        chk("reset_plot", int'(plot), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_x", int'(x), 0);
        chk("reset_colour", int'(colourOut), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            run_fill(vecs[i], 0, 0);
        end

        // start and input changes mid-fill must not disturb the latched fill
        run_fill(vecs[0], 3, 0);
        run_fill(vecs[5], 4, 0);

        // reset while pixel 3 of a 4x4 fill is on the outputs
        run_fill(vecs[8], 0, 5);
        #1 resetn = 1'b0;
        #1;
        chk("rst_mid_plot", int'(plot), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_x", int'(x), 0);
        chk("rst_mid_y", int'(y), 0);
        chk("rst_mid_colour", int'(colourOut), 0);
        start = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            chk("post_rst_plot", int'(plot), 0);
            chk("post_rst_done", int'(done), 0);
        end
        run_fill(vecs[8], 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
